// File: rtl/sync_pdp_ram.sv
// sync_pdp_ram: double-buffered pseudo-dual-port frame RAM for a 64x32 HUB75 panel.
//
// The fill side writes one pixel per cycle into the back buffer. The scan-out side reads
// one top-half and one bottom-half pixel per cycle from the front buffer. buffer_toggle
// selects the roles. The write bank is buffer_toggle and the read bank is ~buffer_toggle,
// so a write and a read in the same cycle never touch the same bank.
//
// Ports
//   clk              : single clock, rising edge
//   rst_n            : synchronous active-low reset. Clears the read outputs only and
//                      blocks reads and writes. Memory contents are kept.
//   buffer_toggle    : bank select, sampled every edge
//   write_addr       : linear pixel index, row*PANEL_WIDTH + col
//   write_data       : pixel to store
//   write_en         : write strobe
//   read_addr        : pixel index within the top half-panel
//   read_en          : read strobe. When low, the outputs hold their last value.
//   read_data_top    : registered pixel at read_addr (1-cycle latency)
//   read_data_bottom : registered pixel at read_addr + DEPTH/2 (1-cycle latency)
module sync_pdp_ram #(
  parameter int unsigned BITS_PER_PIXEL = 32,
  parameter int unsigned PANEL_WIDTH    = 64,
  parameter int unsigned PANEL_HEIGHT   = 32,
  localparam int unsigned DEPTH         = PANEL_WIDTH * PANEL_HEIGHT,
  localparam int unsigned WA            = $clog2(DEPTH),
  localparam int unsigned RA            = WA - 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      buffer_toggle,
  input  logic [WA-1:0]             write_addr,
  input  logic [BITS_PER_PIXEL-1:0] write_data,
  input  logic                      write_en,
  input  logic [RA-1:0]             read_addr,
  output logic [BITS_PER_PIXEL-1:0] read_data_top,
  output logic [BITS_PER_PIXEL-1:0] read_data_bottom,
  input  logic                      read_en
);

  localparam int unsigned HalfDepth = DEPTH / 2;

  // Each bank is split into top/bottom halves. The scan-out then needs only one read
  // port per array, and every array keeps a simple 1W/1R block-RAM mapping.
  logic [BITS_PER_PIXEL-1:0] bank0_top [HalfDepth];
  logic [BITS_PER_PIXEL-1:0] bank0_bot [HalfDepth];
  logic [BITS_PER_PIXEL-1:0] bank1_top [HalfDepth];
  logic [BITS_PER_PIXEL-1:0] bank1_bot [HalfDepth];

  logic          we_b0_top, we_b0_bot, we_b1_top, we_b1_bot;
  logic          wr_half;
  logic [RA-1:0] wr_idx;

  logic [BITS_PER_PIXEL-1:0] rd_top_d, rd_top_q;
  logic [BITS_PER_PIXEL-1:0] rd_bot_d, rd_bot_q;

  // Write decode: the address MSB selects the half-panel array.
  always_comb begin
    wr_half   = write_addr[WA-1];
    wr_idx    = write_addr[WA-2:0];
    we_b0_top = 1'b0;
    we_b0_bot = 1'b0;
    we_b1_top = 1'b0;
    we_b1_bot = 1'b0;
    if (rst_n && write_en) begin
      we_b0_top = !buffer_toggle && !wr_half;
      we_b0_bot = !buffer_toggle &&  wr_half;
      we_b1_top =  buffer_toggle && !wr_half;
      we_b1_bot =  buffer_toggle &&  wr_half;
    end
  end

  always_ff @(posedge clk) begin
    if (we_b0_top) bank0_top[wr_idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (we_b0_bot) bank0_bot[wr_idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (we_b1_top) bank1_top[wr_idx] <= write_data;
  end

  always_ff @(posedge clk) begin
    if (we_b1_bot) bank1_bot[wr_idx] <= write_data;
  end

  // Read bank is the opposite of the write bank.
  always_comb begin
    rd_top_d = rd_top_q;
    rd_bot_d = rd_bot_q;
    if (read_en) begin
      if (buffer_toggle) begin
        rd_top_d = bank0_top[read_addr];
        rd_bot_d = bank0_bot[read_addr];
      end else begin
        rd_top_d = bank1_top[read_addr];
        rd_bot_d = bank1_bot[read_addr];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_top_q <= '0;
      rd_bot_q <= '0;
    end else begin
      rd_top_q <= rd_top_d;
      rd_bot_q <= rd_bot_d;
    end
  end

  assign read_data_top    = rd_top_q;
  assign read_data_bottom = rd_bot_q;

endmodule

// File: tb/tb_sync_pdp_ram.sv
module tb_sync_pdp_ram;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        buffer_toggle;
  logic [10:0] write_addr;
  logic [31:0] write_data;
  logic        write_en;
  logic [9:0]  read_addr;
  logic [31:0] read_data_top;
  logic [31:0] read_data_bottom;
  logic        read_en;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic [31:0] top;
    logic [31:0] bot;
    logic        chk_bot;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  sync_pdp_ram dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .buffer_toggle    (buffer_toggle),
    .write_addr       (write_addr),
    .write_data       (write_data),
    .write_en         (write_en),
    .read_addr        (read_addr),
    .read_data_top    (read_data_top),
    .read_data_bottom (read_data_bottom),
    .read_en          (read_en)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] top, input logic [31:0] bot, input logic chk_bot);
    exp_t e;
    e.top     = top;
    e.bot     = bot;
    e.chk_bot = chk_bot;
    sb.push_back(e);
  endtask

  // Clock the current stimulus through one edge and compare against the oldest expectation.
  task automatic step_check(input string tag);
    exp_t e;
    step();
    e = sb.pop_front();
    check({tag, "_top"}, read_data_top, e.top);
    if (e.chk_bot) check({tag, "_bot"}, read_data_bottom, e.bot);
  endtask

  initial begin
    rst_n         = 1'b0;
    buffer_toggle = 1'b0;
    write_addr    = '0;
    write_data    = '0;
    write_en      = 1'b0;
    read_addr     = '0;
    read_en       = 1'b1;

    // Reset clears outputs even with read_en high.
    for (int i = 0; i < 2; i++) begin
      push(32'h0, 32'h0, 1'b1);
      step_check("reset0");
    end
    rst_n   = 1'b1;
    read_en = 1'b0;

    // Fill bank0 with the A0 image.
    buffer_toggle = 1'b0;
    write_en      = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      write_addr = 11'(i);
      write_data = 32'h00A0_0000 + i;
      step();
    end
    write_en = 1'b0;

    // Reset again with a write attempt that must be suppressed; outputs cleared.
    rst_n      = 1'b0;
    read_en    = 1'b1;
    write_en   = 1'b1;
    write_addr = 11'd0;
    write_data = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      push(32'h0, 32'h0, 1'b1);
      step_check("reset1");
    end
    rst_n    = 1'b1;
    write_en = 1'b0;

    // Swap and read back the whole front buffer.
    buffer_toggle = 1'b1;
    for (int a = 0; a < 1024; a++) begin
      read_addr = 10'(a);
      push(32'h00A0_0000 + a, 32'h00A0_0400 + a, 1'b1);
      step_check("fill_swap");
    end

    // Bank isolation: write to bank1 while reading bank0.
    write_en   = 1'b1;
    write_addr = 11'd5;
    write_data = 32'hDEAD_BEEF;
    read_addr  = 10'd5;
    push(32'h00A0_0005, 32'h00A0_0405, 1'b1);
    step_check("iso_same_cycle");
    write_en = 1'b0;
    push(32'h00A0_0005, 32'h00A0_0405, 1'b1);
    step_check("iso_bank0");
    buffer_toggle = 1'b0;
    push(32'hDEAD_BEEF, 32'h0, 1'b0);
    step_check("iso_bank1");

    // Hold: outputs keep their value while read_en is low.
    buffer_toggle = 1'b1;
    read_addr     = 10'd3;
    push(32'h00A0_0003, 32'h00A0_0403, 1'b1);
    step_check("hold_rd");
    read_en   = 1'b0;
    read_addr = 10'd700;
    for (int i = 0; i < 2; i++) begin
      push(32'h00A0_0003, 32'h00A0_0403, 1'b1);
      step_check("hold");
    end
    read_en = 1'b1;

    // Concurrent: fill bank1 every cycle while scanning bank0.
    buffer_toggle = 1'b1;
    write_en      = 1'b1;
    for (int i = 0; i < 2048; i++) begin
      write_addr = 11'(i);
      write_data = 32'hB100_0000 + i;
      read_addr  = 10'(i % 1024);
      push(32'h00A0_0000 + (i % 1024), 32'h00A0_0400 + (i % 1024), 1'b1);
      step_check("conc_b0");
    end
    write_en      = 1'b0;
    buffer_toggle = 1'b0;
    for (int a = 0; a < 1024; a++) begin
      read_addr = 10'(a);
      push(32'hB100_0000 + a, 32'hB100_0400 + a, 1'b1);
      step_check("conc_b1");
    end

    // Edge addresses in bank0.
    buffer_toggle = 1'b0;
    read_en       = 1'b0;
    write_en      = 1'b1;
    write_addr = 11'd1023; write_data = 32'h1; step();
    write_addr = 11'd1024; write_data = 32'h2; step();
    write_addr = 11'd2047; write_data = 32'h3; step();
    write_en      = 1'b0;
    buffer_toggle = 1'b1;
    read_en       = 1'b1;
    read_addr     = 10'd1023;
    push(32'h1, 32'h3, 1'b1);
    step_check("edge_1023");
    read_addr = 10'd0;
    push(32'h00A0_0000, 32'h2, 1'b1);
    step_check("edge_0");

    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
